comp_div: RTL and testbench

Sequential fixed-point complex divider. It computes (Re1 + jIm1) / (Re2 + jIm2) as ((Re1·Re2 + Im1·Im2) + j(Im1·Re2 − Re1·Im2)) / (Re2² + Im2²). Inputs arrive over a valid/ready handshake, and a one-bit-per-cycle restoring divider produces saturated quotients. It sits in the FFT datapath as the inverse of the complex multiplier, for equalisation and normalisation after the transform.

---
 rtl/comp_div_pkg.sv | 31 +++
 rtl/comp_div_serial_udiv.sv | 73 +++++++
 rtl/comp_div.sv | 188 ++++++++++++++++++
 tb/tb_comp_div.sv | 297 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/comp_div_pkg.sv
`default_nettype none
// ============================================================================
// Module      : comp_div_pkg
// Description : Shared constants and helpers for the comp_div complex divider:
//               FSM state encodings, internal width rule, saturation constant.
// Revision    : 1.0 - initial release
// ============================================================================
package comp_div_pkg;

    // FSM state encodings
    localparam logic [2:0] c_idle  = 3'd0;
    localparam logic [2:0] c_prod  = 3'd1;
    localparam logic [2:0] c_check = 3'd2;
    localparam logic [2:0] c_div   = 3'd3;
    localparam logic [2:0] c_done  = 3'd4;

    // Numerator/denominator carry one bit beyond the product width so that a
    // sum of two full-scale products cannot wrap.
    localparam int c_wide_extra = 1;

    function automatic int wide_width(input int in_w);
        return 2 * in_w + c_wide_extra;
    endfunction

    // Largest positive output value; the clamp is symmetric around zero.
    function automatic int sat_max(input int out_w);
        return (1 << (out_w - 1)) - 1;
    endfunction

endpackage
`default_nettype wire

// File: rtl/comp_div_serial_udiv.sv
`default_nettype none
// ============================================================================
// Module      : serial_udiv
// Description : Restoring unsigned divider, one quotient bit per clock, MSB
//               first. The start cycle already produces the first quotient
//               bit; QW-1 further cycles follow while busy is high. The
//               caller guarantees dividend < divisor * 2^QW, so the upper
//               VW bits of the dividend form a valid starting remainder.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_udiv #(
    parameter int DW = 44,
    parameter int VW = 29,
    parameter int QW = 15
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          start,
    input  logic [DW-1:0] dividend,
    input  logic [VW-1:0] divisor,
    output logic          busy,
    output logic [QW-1:0] quotient
);

    localparam int c_cw = $clog2(QW + 1);

    logic [VW-1:0]   r_rem;
    logic [QW-1:0]   r_bits;
    logic [QW-1:0]   r_quo;
    logic [VW-1:0]   r_div;
    logic [c_cw-1:0] r_cnt;

    logic [VW-1:0]   w_rem_cur;
    logic [QW-1:0]   w_bits_cur;
    logic [QW-1:0]   w_quo_cur;
    logic [VW-1:0]   w_div_cur;
    logic [VW:0]     w_trial;
    logic            w_qbit;
    logic [VW-1:0]   w_rem_next;

    // One restoring step, fed straight from the inputs on the start cycle
    always_comb begin
        w_rem_cur  = start ? dividend[DW-1:QW] : r_rem;
        w_bits_cur = start ? dividend[QW-1:0]  : r_bits;
        w_quo_cur  = start ? '0                : r_quo;
        w_div_cur  = start ? divisor           : r_div;
        w_trial    = {w_rem_cur, w_bits_cur[QW-1]};
        w_qbit     = (w_trial >= {1'b0, w_div_cur});
        w_rem_next = w_qbit ? VW'(w_trial - {1'b0, w_div_cur}) : w_trial[VW-1:0];
    end

    // Iteration state: remainder, pending dividend bits, quotient, count
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rem  <= '0;
            r_bits <= '0;
            r_quo  <= '0;
            r_div  <= '0;
            r_cnt  <= '0;
        end else if (start || (r_cnt != '0)) begin
            r_rem  <= w_rem_next;
            r_bits <= w_bits_cur << 1;
            r_quo  <= (w_quo_cur << 1) | QW'(w_qbit);
            r_div  <= w_div_cur;
            r_cnt  <= start ? c_cw'(QW - 1) : r_cnt - 1'b1;
        end
    end

    assign busy     = (r_cnt != '0);
    assign quotient = r_quo;

endmodule
`default_nettype wire

// File: rtl/comp_div.sv
`default_nettype none
// ============================================================================
// Module      : comp_div
// Description : Sequential fixed-point complex divider
//               (Re1 + jIm1) / (Re2 + jIm2) with valid/ready handshakes,
//               symmetric saturation and divide-by-zero flag.
//               Define COMP_DIV_ROUND_EN for round-half-away-from-zero
//               (one extra divide cycle); default truncates toward zero.
// Revision    : 1.0 - initial release
// ============================================================================
module comp_div
    import comp_div_pkg::*;
#(
    parameter int IN_WIDTH  = 14,
    parameter int OUT_WIDTH = 16,
    parameter int FRAC_BITS = 13
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic                        in_valid,
    output logic                        in_ready,
    input  logic signed [IN_WIDTH-1:0]  Re1,
    input  logic signed [IN_WIDTH-1:0]  Im1,
    input  logic signed [IN_WIDTH-1:0]  Re2,
    input  logic signed [IN_WIDTH-1:0]  Im2,
    output logic                        out_valid,
    input  logic                        out_ready,
    output logic signed [OUT_WIDTH-1:0] Re,
    output logic signed [OUT_WIDTH-1:0] Im,
    output logic                        sat,
    output logic                        div_zero
);

`ifdef COMP_DIV_ROUND_EN
    localparam int c_rnd = 1;
`else
    localparam int c_rnd = 0;
`endif
    localparam int c_pw = 2 * IN_WIDTH;
    localparam int c_nw = wide_width(IN_WIDTH);
    localparam int c_qw = OUT_WIDTH - 1 + c_rnd;
    localparam int c_dw = c_qw + c_nw;
    localparam int c_ew = c_nw + OUT_WIDTH;
    localparam logic [OUT_WIDTH-1:0] c_satmax = OUT_WIDTH'(sat_max(OUT_WIDTH));

    logic [2:0]                 r_state;
    logic signed [IN_WIDTH-1:0] r_re1, r_im1, r_re2, r_im2;
    logic signed [c_pw-1:0]     r_p_a, r_p_b, r_p_c, r_p_d, r_s_re, r_s_im;
    logic                       r_sgn_re, r_sgn_im, r_ovf_re, r_ovf_im, r_dz;

    logic [c_nw-1:0]      w_n_re, w_n_im, w_den, w_mag_re, w_mag_im;
    logic [c_dw-1:0]      w_dvd_re, w_dvd_im;
    logic                 w_start, w_busy_re, w_busy_im;
    logic [c_qw-1:0]      w_quo_re, w_quo_im;
    logic [OUT_WIDTH-1:0] w_qm_re, w_qm_im, w_cm_re, w_cm_im, w_res_re, w_res_im;
    logic                 w_clamp_re, w_clamp_im;

    // Quotient magnitude; with rounding the LSB is a half bit added back in
    function automatic logic [OUT_WIDTH-1:0] q_to_mag(input logic [c_qw-1:0] q);
`ifdef COMP_DIV_ROUND_EN
        return OUT_WIDTH'(q[c_qw-1:1]) + OUT_WIDTH'(q[0]);
`else
        return OUT_WIDTH'(q);
`endif
    endfunction

    // Numerators and denominator in the widened domain, then sign/magnitude
    assign w_n_re   = {r_p_a[c_pw-1], r_p_a} + {r_p_b[c_pw-1], r_p_b};
    assign w_n_im   = {r_p_c[c_pw-1], r_p_c} - {r_p_d[c_pw-1], r_p_d};
    assign w_den    = {1'b0, r_s_re} + {1'b0, r_s_im};
    assign w_mag_re = w_n_re[c_nw-1] ? -w_n_re : w_n_re;
    assign w_mag_im = w_n_im[c_nw-1] ? -w_n_im : w_n_im;
    assign w_dvd_re = c_dw'(w_mag_re) << (FRAC_BITS + c_rnd);
    assign w_dvd_im = c_dw'(w_mag_im) << (FRAC_BITS + c_rnd);
    assign w_start  = (r_state == c_check);

    serial_udiv #(.DW(c_dw), .VW(c_nw), .QW(c_qw)) u_div_re (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_dvd_re),
        .divisor  (w_den),
        .busy     (w_busy_re),
        .quotient (w_quo_re)
    );

    serial_udiv #(.DW(c_dw), .VW(c_nw), .QW(c_qw)) u_div_im (
        .clk      (clk),
        .rst      (rst),
        .start    (w_start),
        .dividend (w_dvd_im),
        .divisor  (w_den),
        .busy     (w_busy_im),
        .quotient (w_quo_im)
    );

    // Per-lane clamp (pre-check overflow or rounding carry) and sign restore
    assign w_qm_re    = q_to_mag(w_quo_re);
    assign w_qm_im    = q_to_mag(w_quo_im);
    assign w_clamp_re = r_ovf_re | (w_qm_re > c_satmax);
    assign w_clamp_im = r_ovf_im | (w_qm_im > c_satmax);
    assign w_cm_re    = w_clamp_re ? c_satmax : w_qm_re;
    assign w_cm_im    = w_clamp_im ? c_satmax : w_qm_im;
    assign w_res_re   = r_sgn_re ? -w_cm_re : w_cm_re;
    assign w_res_im   = r_sgn_im ? -w_cm_im : w_cm_im;

    assign in_ready  = (r_state == c_idle);
    assign out_valid = (r_state == c_done);

    // Control FSM with operand, product, flag and result registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state  <= c_idle;
            r_re1    <= '0;
            r_im1    <= '0;
            r_re2    <= '0;
            r_im2    <= '0;
            r_p_a    <= '0;
            r_p_b    <= '0;
            r_p_c    <= '0;
            r_p_d    <= '0;
            r_s_re   <= '0;
            r_s_im   <= '0;
            r_sgn_re <= 1'b0;
            r_sgn_im <= 1'b0;
            r_ovf_re <= 1'b0;
            r_ovf_im <= 1'b0;
            r_dz     <= 1'b0;
            Re       <= '0;
            Im       <= '0;
            sat      <= 1'b0;
            div_zero <= 1'b0;
        end else begin
            case (r_state)
                c_idle: begin
                    if (in_valid) begin
                        r_re1   <= Re1;
                        r_im1   <= Im1;
                        r_re2   <= Re2;
                        r_im2   <= Im2;
                        r_state <= c_prod;
                    end
                end
                c_prod: begin
                    r_p_a   <= c_pw'(r_re1) * c_pw'(r_re2);
                    r_p_b   <= c_pw'(r_im1) * c_pw'(r_im2);
                    r_p_c   <= c_pw'(r_im1) * c_pw'(r_re2);
                    r_p_d   <= c_pw'(r_re1) * c_pw'(r_im2);
                    r_s_re  <= c_pw'(r_re2) * c_pw'(r_re2);
                    r_s_im  <= c_pw'(r_im2) * c_pw'(r_im2);
                    r_state <= c_check;
                end
                c_check: begin
                    r_sgn_re <= w_n_re[c_nw-1];
                    r_sgn_im <= w_n_im[c_nw-1];
                    r_ovf_re <= (c_ew'(w_mag_re) << FRAC_BITS) >= (c_ew'(w_den) << (OUT_WIDTH - 1));
                    r_ovf_im <= (c_ew'(w_mag_im) << FRAC_BITS) >= (c_ew'(w_den) << (OUT_WIDTH - 1));
                    r_dz     <= (w_den == '0);
                    r_state  <= c_div;
                end
                c_div: begin
                    if (!(w_busy_re || w_busy_im)) begin
                        if (r_dz) begin
                            Re       <= '0;
                            Im       <= '0;
                            sat      <= 1'b0;
                            div_zero <= 1'b1;
                        end else begin
                            Re       <= w_res_re;
                            Im       <= w_res_im;
                            sat      <= w_clamp_re | w_clamp_im;
                            div_zero <= 1'b0;
                        end
                        r_state <= c_done;
                    end
                end
                c_done: begin
                    if (out_ready) begin
                        r_state <= c_idle;
                    end
                end
                default: r_state <= c_idle;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_comp_div.sv
`default_nettype none
// ============================================================================
// Module      : tb_comp_div
// Description : Directed self-checking bench for comp_div (default params).
//               Honours COMP_DIV_ROUND_EN for expected values and latency.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_comp_div;

`ifdef COMP_DIV_ROUND_EN
    localparam int c_lat = 18;
    localparam int c_rnd = 1;
`else
    localparam int c_lat = 17;
    localparam int c_rnd = 0;
`endif

    logic               clk = 1'b0;
    logic               rst;
    logic               in_valid;
    logic               in_ready;
    logic signed [13:0] Re1, Im1, Re2, Im2;
    logic               out_valid;
    logic               out_ready;
    logic signed [15:0] Re, Im;
    logic               sat, div_zero;

    int checks   = 0;
    int failures = 0;

    comp_div #(.IN_WIDTH(14), .OUT_WIDTH(16), .FRAC_BITS(13)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .Re1       (Re1),
        .Im1       (Im1),
        .Re2       (Re2),
        .Im2       (Im2),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .Re        (Re),
        .Im        (Im),
        .sat       (sat),
        .div_zero  (div_zero)
    );

    always #5 clk = ~clk;

    // Stimulus only: present operands, wait for result, capture, handshake
    task automatic run_op(input int a, input int b, input int c, input int d,
                          output int re, output int im, output int s, output int z,
                          output int lat);
        @(negedge clk);
        Re1 = 14'(a); Im1 = 14'(b); Re2 = 14'(c); Im2 = 14'(d);
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk);
            lat++;
            #1;
            if (out_valid) break;
        end
        re = int'(Re); im = int'(Im); s = int'(sat); z = int'(div_zero);
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b1; out_ready = 1'b0;
        Re1 = 14'sd5; Im1 = 14'sd5; Re2 = 14'sd1; Im2 = 14'sd0;
        repeat (3) @(posedge clk);
        #1;
        checks++;
        if (out_valid !== 1'b0 || Re !== 16'sd0 || Im !== 16'sd0 || sat !== 1'b0 || div_zero !== 1'b0) begin
            failures++;
            $display("FAIL reset_outputs: got ov=%0b re=%0d im=%0d sat=%0b dz=%0b, expected all 0",
                     out_valid, Re, Im, sat, div_zero);
        end
        checks++;
        if (in_ready !== 1'b1) begin
            failures++;
            $display("FAIL reset_in_ready: got %0b, expected 1", in_ready);
        end
        @(negedge clk);
        rst = 1'b0; in_valid = 1'b0;
        begin
            int seen = 0;
            repeat (25) begin
                @(posedge clk);
                #1;
                if (out_valid) seen++;
            end
            checks++;
            if (seen != 0) begin
                failures++;
                $display("FAIL reset_in_valid_ignored: out_valid high %0d cycles, expected 0", seen);
            end
        end
    endtask

    task automatic test_basic();
        int ta[4]  = '{100, 0,    100, 3};
        int tb_[4] = '{0,   100,  0,   4};
        int tc[4]  = '{100, 100,  0,   1};
        int td[4]  = '{0,   0,    100, 2};
        int er[4]  = '{8192, 0,    0,     18022};
        int ei[4]  = '{0,    8192, -8192, (c_rnd != 0) ? -3277 : -3276};
        int re, im, s, z, lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb_[i], tc[i], td[i], re, im, s, z, lat);
            checks++;
            if (re != er[i] || im != ei[i] || s != 0 || z != 0 || lat != c_lat) begin
                failures++;
                $display("FAIL basic_%0d: got re=%0d im=%0d sat=%0d dz=%0d lat=%0d, expected re=%0d im=%0d sat=0 dz=0 lat=%0d",
                         i, re, im, s, z, lat, er[i], ei[i], c_lat);
            end
        end
    endtask

    task automatic test_rounding();
        int ta[2] = '{1, -1};
        int er[2] = '{(c_rnd != 0) ? 2731 : 2730, (c_rnd != 0) ? -2731 : -2730};
        int re, im, s, z, lat;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], 0, 3, 0, re, im, s, z, lat);
            checks++;
            if (re != er[i] || im != 0 || s != 0 || z != 0 || lat != c_lat) begin
                failures++;
                $display("FAIL round_%0d: got re=%0d im=%0d sat=%0d dz=%0d lat=%0d, expected re=%0d im=0 sat=0 dz=0 lat=%0d",
                         i, re, im, s, z, lat, er[i], c_lat);
            end
        end
    endtask

    task automatic test_saturation();
        int ta[4] = '{8000,  4,     -4,     4095};
        int tb_[4] = '{-8000, 0,     0,      0};
        int tc[4] = '{1,     1,     1,      1024};
        int er[4] = '{32767, 32767, -32767, 32760};
        int ei[4] = '{-32767, 0,    0,      0};
        int es[4] = '{1,     1,     1,      0};
        int re, im, s, z, lat;
        for (int i = 0; i < 4; i++) begin
            run_op(ta[i], tb_[i], tc[i], 0, re, im, s, z, lat);
            checks++;
            if (re != er[i] || im != ei[i] || s != es[i] || z != 0 || lat != c_lat) begin
                failures++;
                $display("FAIL sat_%0d: got re=%0d im=%0d sat=%0d dz=%0d lat=%0d, expected re=%0d im=%0d sat=%0d dz=0 lat=%0d",
                         i, re, im, s, z, lat, er[i], ei[i], es[i], c_lat);
            end
        end
    endtask

    task automatic test_div_zero();
        int ta[2] = '{5, 0};
        int re, im, s, z, lat;
        for (int i = 0; i < 2; i++) begin
            run_op(ta[i], ta[i], 0, 0, re, im, s, z, lat);
            checks++;
            if (re != 0 || im != 0 || s != 0 || z != 1 || lat != c_lat) begin
                failures++;
                $display("FAIL divzero_%0d: got re=%0d im=%0d sat=%0d dz=%0d lat=%0d, expected re=0 im=0 sat=0 dz=1 lat=%0d",
                         i, re, im, s, z, lat, c_lat);
            end
        end
    endtask

    task automatic test_back_to_back();
        int lat;
        @(negedge clk);
        Re1 = 14'sd100; Im1 = 14'sd0; Re2 = 14'sd100; Im2 = 14'sd0;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); lat++; #1;
            if (out_valid) break;
        end
        checks++;
        if (lat != c_lat || Re !== 16'sd8192) begin
            failures++;
            $display("FAIL bp_first: got lat=%0d re=%0d, expected lat=%0d re=8192", lat, Re, c_lat);
        end
        // hold off the consumer for 10 cycles
        for (int i = 0; i < 10; i++) begin
            @(posedge clk);
            #1;
            checks++;
            if (out_valid !== 1'b1 || Re !== 16'sd8192 || Im !== 16'sd0 || sat !== 1'b0 || in_ready !== 1'b0) begin
                failures++;
                $display("FAIL bp_hold_%0d: got ov=%0b re=%0d im=%0d sat=%0b ir=%0b, expected ov=1 re=8192 im=0 sat=0 ir=0",
                         i, out_valid, Re, Im, sat, in_ready);
            end
        end
        @(negedge clk);
        out_ready = 1'b1;
        in_valid  = 1'b1;
        Re1 = 14'sd1; Im1 = 14'sd0; Re2 = 14'sd3; Im2 = 14'sd0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1 || out_valid !== 1'b0) begin
            failures++;
            $display("FAIL bp_release: got ir=%0b ov=%0b, expected ir=1 ov=0", in_ready, out_valid);
        end
        @(negedge clk);
        out_ready = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b0) begin
            failures++;
            $display("FAIL bp_accept_next: got ir=%0b, expected 0", in_ready);
        end
        @(negedge clk);
        in_valid = 1'b0;
        lat = 0;
        while (lat < 60) begin
            @(posedge clk); lat++; #1;
            if (out_valid) break;
        end
        checks++;
        if (lat != c_lat || Re !== 16'((c_rnd != 0) ? 2731 : 2730)) begin
            failures++;
            $display("FAIL bp_second: got lat=%0d re=%0d, expected lat=%0d re=%0d",
                     lat, Re, c_lat, (c_rnd != 0) ? 2731 : 2730);
        end
        @(negedge clk);
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        out_ready = 1'b0;
    endtask

    task automatic test_reset_mid();
        int re, im, s, z, lat, seen;
        @(negedge clk);
        Re1 = 14'sd3; Im1 = 14'sd4; Re2 = 14'sd1; Im2 = 14'sd2;
        in_valid = 1'b1;
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        repeat (6) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        checks++;
        if (out_valid !== 1'b0 || Re !== 16'sd0 || Im !== 16'sd0 || sat !== 1'b0 || div_zero !== 1'b0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_outputs: got ov=%0b re=%0d im=%0d sat=%0b dz=%0b ir=%0b, expected 0 0 0 0 0 ir=1",
                     out_valid, Re, Im, sat, div_zero, in_ready);
        end
        @(negedge clk);
        rst = 1'b0;
        seen = 0;
        repeat (25) begin
            @(posedge clk);
            #1;
            if (out_valid) seen++;
        end
        checks++;
        if (seen != 0 || in_ready !== 1'b1) begin
            failures++;
            $display("FAIL midrst_abort: got out_valid cycles=%0d ir=%0b, expected 0 and ir=1", seen, in_ready);
        end
        run_op(-1, 0, 3, 0, re, im, s, z, lat);
        checks++;
        if (re != ((c_rnd != 0) ? -2731 : -2730) || im != 0 || s != 0 || z != 0 || lat != c_lat) begin
            failures++;
            $display("FAIL midrst_fresh: got re=%0d im=%0d sat=%0d dz=%0d lat=%0d, expected re=%0d im=0 sat=0 dz=0 lat=%0d",
                     re, im, s, z, lat, (c_rnd != 0) ? -2731 : -2730, c_lat);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_rounding();
        test_saturation();
        test_div_zero();
        test_back_to_back();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
